// File: rtl/pipe_mux_pkg.sv
// Shared constants for the pipe_mux family: selection-mode encodings.
// Imported by the top level and the testbench.
package pipe_mux_pkg;

    localparam int MUX_MODE_SEL  = 0;
    localparam int MUX_MODE_RR   = 1;
    localparam int MUX_MODE_PRIO = 2;

endpackage

// File: rtl/pipe_mux_if.sv
// N-channel valid/ready input bundle plus single registered output channel.
// master drives channels and out_ready; slave is the mux itself.
interface pipe_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
);
    logic [SEL_W-1:0]   sel;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;

    modport master (
        output sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/pipe_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr, wrapping mod N.
// Zero latency; ptr=0 degenerates to fixed lowest-index priority.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [N-1:0] masked;

    // Lowest requester at/above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        masked  = '0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (SEL_W'(i) >= ptr);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) gnt_idx = SEL_W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) gnt_idx = SEL_W'(i);
        end
    end

    assign gnt_vld = |req;

endmodule

// File: rtl/pipe_mux.sv
// N-way registered valid/ready mux (external select, round-robin or fixed priority).
// 1-cycle latency, full throughput; a held beat stalls all inputs until out_ready drains it.
module pipe_mux
    import pipe_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MUX_MODE_SEL,
    localparam int SEL_W = $clog2(N)
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_mux_if.slave  bus
);

    logic             load;
    logic             grant;
    logic             accept;
    logic [SEL_W-1:0] gnt_idx;
    logic [N-1:0]     rdy;
    logic [WIDTH-1:0] ch_dat [N];

    logic             out_vld_q;
    logic [WIDTH-1:0] out_dat_q;
    logic [SEL_W-1:0] out_src_q;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_dat[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    if (MODE == MUX_MODE_SEL) begin : g_sel
        // Non-power-of-2 N leaves select codes that name no channel.
        assign grant   = 32'(bus.sel) < N;
        assign gnt_idx = bus.sel;
    end else begin : g_arb
        logic [SEL_W-1:0] arb_ptr;
        wire  [SEL_W-1:0] unused_sel = bus.sel;

        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr <= '0;
                end else if (accept) begin
                    rr_ptr <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + SEL_W'(1);
                end
            end

            assign arb_ptr = rr_ptr;
        end else begin : g_prio
            assign arb_ptr = '0;
        end

        rr_arbiter #(.N(N)) u_arb (
            .req     (bus.in_valid),
            .ptr     (arb_ptr),
            .gnt_vld (grant),
            .gnt_idx (gnt_idx)
        );
    end

    assign load   = !out_vld_q || bus.out_ready;
    assign accept = load && grant && bus.in_valid[gnt_idx];

    always_comb begin
        rdy = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = rst_n && load && grant && (gnt_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_src_q <= '0;
        end else if (load) begin
            out_vld_q <= accept;
            if (accept) begin
                out_dat_q <= ch_dat[gnt_idx];
                out_src_q <= gnt_idx;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;
    assign bus.out_src   = out_src_q;

endmodule
